// File: rtl/jpeg_zigzag_pkg.sv
// Shared JPEG zig-zag definitions: scan-order tables, block size, coefficient type.
// Used by the serializer, the run-length stage and any inverse-zig-zag model.
// ZZ_ROW/ZZ_COL map zig-zag index 0..63 to (row, col) of an 8x8 block.
package jpeg_zigzag_pkg;

  localparam int COEF_W    = 11;
  localparam int BLK_COEFS = 64;

  typedef logic signed [COEF_W-1:0] coef_t;

  localparam logic [2:0] ZZ_ROW [0:63] = '{
    3'd0, 3'd0, 3'd1, 3'd2, 3'd1, 3'd0, 3'd0, 3'd1, 3'd2, 3'd3,
    3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4,
    3'd5, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd0, 3'd1,
    3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd7, 3'd6, 3'd5, 3'd4,
    3'd3, 3'd2, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd7,
    3'd6, 3'd5, 3'd4, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd7, 3'd6,
    3'd5, 3'd6, 3'd7, 3'd7
  };

  localparam logic [2:0] ZZ_COL [0:63] = '{
    3'd0, 3'd1, 3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd2, 3'd1, 3'd0,
    3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1,
    3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd6,
    3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4,
    3'd5, 3'd6, 3'd7, 3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd3,
    3'd4, 3'd5, 3'd6, 3'd7, 3'd7, 3'd6, 3'd5, 3'd4, 3'd5, 3'd6,
    3'd7, 3'd7, 3'd6, 3'd7
  };

endpackage

// File: rtl/zz_block_buffer.sv
// Two-slot ping-pong store for 8x8 coefficient blocks with write/read pointers and fill count.
// Latency: a block written at edge N is readable the cycle after; read port is combinational off registers.
// Backpressure: none internally; the owner must only assert wr_en while count < NUM_SLOTS.
// Ports: clk/rst (sync, active-high); wr_en/wr_block capture a block into slot[wr_ptr];
//        rd_adv retires slot[rd_ptr]; rd_row/rd_col select a coefficient; count = blocks held.
module zz_block_buffer #(
  parameter int DATA_W    = 11,
  parameter int NUM_SLOTS = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            wr_en,
  input  logic [0:7][0:7][DATA_W-1:0]     wr_block,
  input  logic                            rd_adv,
  input  logic [2:0]                      rd_row,
  input  logic [2:0]                      rd_col,
  output logic [DATA_W-1:0]               rd_data,
  output logic [1:0]                      count
);

  logic [0:7][0:7][DATA_W-1:0] slot [0:NUM_SLOTS-1];
  logic                        wr_ptr;
  logic                        rd_ptr;

  // Slot contents carry no reset; count alone decides what is meaningful.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      slot[wr_ptr] <= wr_block;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (wr_en)  wr_ptr <= ~wr_ptr;
      if (rd_adv) rd_ptr <= ~rd_ptr;
      // Capture and retire in the same cycle cancel out in the count.
      case ({wr_en, rd_adv})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign rd_data = slot[rd_ptr][rd_row][rd_col];

endmodule

// File: rtl/zigzag_serializer.sv
// Buffers quantized 8x8 blocks (two slots) and streams them out one coefficient per beat in zig-zag order.
// Latency: idx 0 of a block captured at edge N is presented the next cycle when idle, else right after the current block.
// Backpressure: out_ready stalls the stream; the input cannot be stalled, so a block arriving with both slots full is dropped and overflow sticks.
// Ports: clk/rst (sync, active-high); in_valid/in_block/in_ready block input; out_data/out_idx/out_valid/
//        out_ready/out_first/out_last coefficient stream; overflow sticky drop flag.
module zigzag_serializer
  import jpeg_zigzag_pkg::*;
#(
  parameter int DATA_W    = 11,
  parameter int NUM_SLOTS = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic [0:7][0:7][DATA_W-1:0]  in_block,
  output logic                         in_ready,
  output logic signed [DATA_W-1:0]     out_data,
  output logic [5:0]                   out_idx,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         out_first,
  output logic                         out_last,
  output logic                         overflow
);

  logic [5:0]        idx;
  logic [1:0]        count;
  logic [DATA_W-1:0] rd_data;
  logic [2:0]        rd_row;
  logic [2:0]        rd_col;
  logic              capture;
  logic              beat;
  logic              retire;

  assign in_ready  = (count < 2'(NUM_SLOTS));
  assign out_valid = (count != 2'd0);
  assign capture   = in_valid && in_ready;
  assign beat      = out_valid && out_ready;
  assign retire    = beat && (idx == 6'(BLK_COEFS - 1));

  assign rd_row = ZZ_ROW[idx];
  assign rd_col = ZZ_COL[idx];

  zz_block_buffer #(
    .DATA_W    (DATA_W),
    .NUM_SLOTS (NUM_SLOTS)
  ) u_buf (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (capture),
    .wr_block (in_block),
    .rd_adv   (retire),
    .rd_row   (rd_row),
    .rd_col   (rd_col),
    .rd_data  (rd_data),
    .count    (count)
  );

  // idx wraps 63 -> 0 on its own, which lines up with the slot retire.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx      <= 6'd0;
      overflow <= 1'b0;
    end else begin
      if (beat) idx <= idx + 6'd1;
      if (in_valid && !in_ready) overflow <= 1'b1;
    end
  end

  // Force data to zero when idle so uninitialised slots never show on the bus.
  assign out_data  = out_valid ? signed'(rd_data) : '0;
  assign out_idx   = idx;
  assign out_first = out_valid && (idx == 6'd0);
  assign out_last  = out_valid && (idx == 6'(BLK_COEFS - 1));

endmodule

// File: tb/tb_zigzag_serializer.sv
// Directed bench for zigzag_serializer: reset, ordering, backpressure, overflow,
// simultaneous capture/retire, negative values and reset mid-block.
// Expected values come from a row-major zig-zag position table held here.
module tb_zigzag_serializer;

  localparam int DATA_W = 11;

  logic                        clk = 1'b0;
  logic                        rst;
  logic                        in_valid;
  logic [0:7][0:7][DATA_W-1:0] in_block;
  logic                        in_ready;
  logic signed [DATA_W-1:0]    out_data;
  logic [5:0]                  out_idx;
  logic                        out_valid;
  logic                        out_ready;
  logic                        out_first;
  logic                        out_last;
  logic                        overflow;

  int checks = 0;
  int errors = 0;
  int beats;

  // Row-major position (r*8+c) of each zig-zag index.
  int zz_lin [0:63] = '{
     0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
    12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
    35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
    58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
  };

  always #5 clk = ~clk;

  zigzag_serializer #(.DATA_W(DATA_W), .NUM_SLOTS(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_block  (in_block),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_first (out_first),
    .out_last  (out_last),
    .overflow  (overflow)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Block patterns: 0 ramp, 1 negative ramp, 2 constant, 3 -1024 with 1023 at (7,7), 4 ramp+300.
  function automatic int value_of(input int mode, input int lin);
    case (mode)
      0:       return lin;
      1:       return -lin - 1;
      2:       return 777;
      3:       return (lin == 63) ? 1023 : -1024;
      default: return lin + 300;
    endcase
  endfunction

  function automatic int exp_val(input int mode, input int k);
    return value_of(mode, zz_lin[k]);
  endfunction

  task automatic set_blk(input int mode);
    int v;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        v = value_of(mode, r * 8 + c);
        in_block[r][c] = DATA_W'(v);
      end
  endtask

  task automatic capture(input int mode);
    set_blk(mode);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic stream(input int mode, input string tag);
    out_ready = 1'b1;
    for (int k = 0; k < 64; k++) begin
      chk({tag, "_valid"}, out_valid, 1);
      chk({tag, "_data"},  out_data,  exp_val(mode, k));
      chk({tag, "_idx"},   out_idx,   k);
      chk({tag, "_first"}, out_first, (k == 0) ? 1 : 0);
      chk({tag, "_last"},  out_last,  (k == 63) ? 1 : 0);
      tick();
    end
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    set_blk(0);

    // Reset, with a block strobed while reset is held.
    set_blk(2);
    in_valid = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    in_valid = 1'b0;
    chk("rst_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_overflow", overflow, 0);
    chk("rst_idx", out_idx, 0);
    chk("rst_first", out_first, 0);
    chk("rst_last", out_last, 0);
    chk("rst_data", out_data, 0);
    tick();
    chk("rst_nocap_valid", out_valid, 0);
    chk("rst_nocap_in_ready", in_ready, 1);

    // Ordering with out_ready held high; beat 0 the cycle after capture.
    out_ready = 1'b1;
    capture(0);
    stream(0, "order");
    chk("order_drain", out_valid, 0);

    // Random backpressure: same sequence, outputs tracked against the model every cycle.
    capture(0);
    beats = 0;
    for (int cyc = 0; cyc < 2000 && beats < 64; cyc++) begin
      out_ready = 1'($urandom_range(0, 1));
      chk("bp_valid", out_valid, 1);
      chk("bp_data", out_data, exp_val(0, beats));
      chk("bp_idx", out_idx, beats);
      if (out_ready) beats++;
      tick();
    end
    chk("bp_beats", beats, 64);
    chk("bp_drain", out_valid, 0);

    // Overflow: three back-to-back blocks while stalled.
    out_ready = 1'b0;
    capture(0);
    chk("ovf_in_ready1", in_ready, 1);
    capture(1);
    chk("ovf_in_ready2", in_ready, 0);
    chk("ovf_flag2", overflow, 0);
    capture(2);
    chk("ovf_flag3", overflow, 1);
    chk("ovf_in_ready3", in_ready, 0);
    chk("ovf_hold_idx", out_idx, 0);
    chk("ovf_hold_data", out_data, exp_val(0, 0));
    repeat (3) tick();
    chk("ovf_sticky", overflow, 1);
    out_ready = 1'b1;
    beats = 0;
    for (int n = 0; n < 400 && out_valid; n++) begin
      chk("ovf_data", out_data, exp_val((beats < 64) ? 0 : 1, beats % 64));
      chk("ovf_idx", out_idx, beats % 64);
      beats++;
      tick();
    end
    chk("ovf_beats", beats, 128);
    chk("ovf_sticky_end", overflow, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("ovf_cleared", overflow, 0);

    // Capture in the same cycle as the idx-63 transfer.
    out_ready = 1'b1;
    capture(0);
    for (int k = 0; k < 63; k++) begin
      chk("sim_a_data", out_data, exp_val(0, k));
      tick();
    end
    chk("sim_a_idx63", out_idx, 63);
    chk("sim_a_last", out_last, 1);
    set_blk(1);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("sim_b_valid", out_valid, 1);
    chk("sim_b_idx", out_idx, 0);
    chk("sim_b_first", out_first, 1);
    chk("sim_b_data", out_data, exp_val(1, 0));
    chk("sim_b_in_ready", in_ready, 1);
    chk("sim_overflow", overflow, 0);
    stream(1, "sim_b");
    chk("sim_drain", out_valid, 0);

    // Extreme negative values with the positive maximum last.
    capture(3);
    stream(3, "neg");
    chk("neg_drain", out_valid, 0);

    // Reset mid-block with a second block buffered.
    out_ready = 1'b1;
    capture(0);
    set_blk(1);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("mid_in_ready", in_ready, 0);
    for (int n = 0; n < 100 && out_idx != 6'd20; n++) tick();
    chk("mid_idx20", out_idx, 20);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_idx", out_idx, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    tick();
    chk("mid_discarded", out_valid, 0);
    capture(4);
    stream(4, "mid_new");
    chk("mid_drain", out_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
